// File: rtl/seq_binary_mac_pkg.sv
// Shared types, lane-contribution encoding and width helper for seq_binary_mac.
package seq_binary_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic signed [1:0] LANE_POS  = 2'sb01;
  localparam logic signed [1:0] LANE_ZERO = 2'sb00;
  localparam logic signed [1:0] LANE_NEG  = 2'sb11;

  // Chunk sum needs N_STAGE+2 bits; each doubling of chunk count adds one bit.
  function automatic int acc_width(input int n_stage, input int n_chunks);
    return n_stage + 2 + $clog2(n_chunks);
  endfunction

endpackage

// File: rtl/binary_chunk_sum.sv
// Lane decoders (spike x, binary weight w) feeding a log2 adder tree that
// produces the signed N_STAGE+2-bit sum of one chunk.
module binary_chunk_sum
  import seq_binary_mac_pkg::*;
#(
  parameter int N_STAGE = 6,
  localparam int LANES = 2 ** N_STAGE,
  localparam int SW = N_STAGE + 2
) (
  input  logic [LANES-1:0]     x,
  input  logic [LANES-1:0]     w,
  output logic signed [SW-1:0] chunk_sum
);

  logic signed [SW-1:0] tree [N_STAGE+1][LANES];
  logic signed [1:0]    lane;

  always_comb begin
    lane = LANE_ZERO;
    for (int s = 0; s <= N_STAGE; s++) begin
      for (int i = 0; i < LANES; i++) begin
        tree[s][i] = '0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      lane = x[i] ? (w[i] ? LANE_POS : LANE_NEG) : LANE_ZERO;
      tree[0][i] = SW'(lane);
    end
    // Level s+1 holds half as many partial sums as level s.
    for (int s = 0; s < N_STAGE; s++) begin
      for (int i = 0; i < (LANES >> (s + 1)); i++) begin
        tree[s+1][i] = tree[s][2*i] + tree[s][2*i+1];
      end
    end
  end

  assign chunk_sum = tree[N_STAGE][0];

endmodule

// File: rtl/seq_binary_mac.sv
// Sequential signed binary dot product over N_CHUNKS beats of LANES lanes.
// Optional macro SEQ_BINARY_MAC_PIPE_EN registers the chunk sum and adds a FLUSH state.
module seq_binary_mac
  import seq_binary_mac_pkg::*;
#(
  parameter int N_STAGE = 6,
  parameter int N_CHUNKS = 4,
  localparam int LANES = 2 ** N_STAGE,
  localparam int ACC_W = acc_width(N_STAGE, N_CHUNKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] w,
  input  logic [LANES-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a beat transfers on a clock edge where in_valid && in_ready;
  // a result transfers where out_valid && out_ready. Valid/data hold until taken.
  localparam int CSW = N_STAGE + 2;
  localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic signed [CSW-1:0]   chunk_sum, add_val;
  logic                    accept, last_beat, add_en;

  binary_chunk_sum #(.N_STAGE(N_STAGE)) u_chunk (
    .x        (x),
    .w        (w),
    .chunk_sum(chunk_sum)
  );

  assign accept    = (state == ACCUM) && in_valid;
  assign last_beat = accept && (cnt == LAST_CNT);

`ifdef SEQ_BINARY_MAC_PIPE_EN
  logic signed [CSW-1:0] pipe_sum;
  logic                  pipe_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_sum   <= '0;
      pipe_valid <= 1'b0;
    end else begin
      pipe_valid <= accept;
      if (accept) pipe_sum <= chunk_sum;
    end
  end

  assign add_val = pipe_sum;
  assign add_en  = pipe_valid;
`else
  assign add_val = chunk_sum;
  assign add_en  = accept;
`endif

  assign acc_sum = acc + ACC_W'(add_val);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
`ifdef SEQ_BINARY_MAC_PIPE_EN
      ACCUM: if (last_beat) state_nxt = FLUSH;
`else
      ACCUM: if (last_beat) state_nxt = DONE;
`endif
      FLUSH: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sum_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        if (add_en) acc <= acc_sum;
        if (accept) cnt <= cnt + CNT_W'(1);
      end
      // The final addition always lands on the DONE-entry edge.
      if (state_nxt == DONE && state != DONE) sum_out <= acc_sum;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
